// File: rtl/online_residue_select_pkg.sv
// Shared constants for the on-line multiplier residue/digit-selection stage.
package online_residue_select_pkg;

    localparam int BITS_DEF  = 4;
    localparam int DELAY_DEF = 5;

    // Residue width: one slot per operand digit plus the on-line delay.
    function automatic int calc_w(input int bits, input int delay);
        return bits + delay;
    endfunction

    // FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Signed-digit encodings {plus, minus}
    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    // Selection thresholds on the 3-digit estimate
    localparam logic signed [4:0] SEL_POS_TH = 5'sd1;
    localparam logic signed [4:0] SEL_NEG_TH = -5'sd2;

endpackage

// File: rtl/online_residue_select_digit.sv
// Combinational digit selector: estimates the top three redundant digits,
// picks z in {-1,0,+1} and re-encodes the remainder e - 4z into the top field.
module online_digit_select
    import online_residue_select_pkg::*;
(
    input  logic [2:0] i_top_plus,
    input  logic [2:0] i_top_minus,
    output logic [1:0] o_z,
    output logic [2:0] o_top_plus,
    output logic [2:0] o_top_minus
);

    logic signed [4:0] w_e;
    logic signed [4:0] w_ep;
    logic [1:0]        w_mag;

    // Estimate, select, and rebuild the top field; position W-1 always ends up 0.
    always_comb begin
        w_e  = $signed({2'b00, i_top_plus}) - $signed({2'b00, i_top_minus});
        o_z  = DIG_ZERO;
        w_ep = w_e;
        if (w_e >= SEL_POS_TH) begin
            o_z  = DIG_POS;
            w_ep = w_e - 5'sd4;
        end else if (w_e <= SEL_NEG_TH) begin
            o_z  = DIG_NEG;
            w_ep = w_e + 5'sd4;
        end
        // |e'| is at most 3, so two bits of magnitude suffice
        w_mag       = w_ep[4] ? (~w_ep[1:0] + 2'd1) : w_ep[1:0];
        o_top_plus  = 3'b000;
        o_top_minus = 3'b000;
        if (w_ep[4])
            o_top_minus = {1'b0, w_mag};
        else if (w_ep != 5'sd0)
            o_top_plus  = {1'b0, w_mag};
    end

endmodule

// File: rtl/online_residue_select.sv
// Residue/digit-selection stage of the on-line signed-digit multiplier.
// Registers the adder's redundant sum as the shifted residue, runs DELAY
// init cycles, then emits one output digit per cycle for BITS cycles.
module online_residue_select
    import online_residue_select_pkg::*;
#(
    parameter  int BITS  = BITS_DEF,
    parameter  int DELAY = DELAY_DEF,
    localparam int W     = calc_w(BITS, DELAY)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [W-1:0] i_sum_plus,
    input  logic [W-1:0] i_sum_minus,
    input  logic [1:0]   i_sum_cout,
    output logic [W-1:0] o_residue_plus,
    output logic [W-1:0] o_residue_minus,
    output logic         o_z_plus,
    output logic         o_z_minus,
    output logic         o_z_valid,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_ovf
);

    localparam int CW = $clog2(W);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_res_p;
    logic [W-1:0]  r_res_m;
    logic [1:0]    r_z;
    logic          r_z_valid;
    logic          r_done;
    logic          r_ovf;

    logic [1:0]    w_z;
    logic [2:0]    w_top_p;
    logic [2:0]    w_top_m;
    logic [W-1:0]  w_new_p;
    logic [W-1:0]  w_new_m;

    online_digit_select u_sel (
        .i_top_plus  (i_sum_plus[W-1:W-3]),
        .i_top_minus (i_sum_minus[W-1:W-3]),
        .o_z         (w_z),
        .o_top_plus  (w_top_p),
        .o_top_minus (w_top_m)
    );

    // Sum with its top three digits replaced by the re-encoded remainder
    assign w_new_p = {w_top_p, i_sum_plus[W-4:0]};
    assign w_new_m = {w_top_m, i_sum_minus[W-4:0]};

    // FSM, cycle counter, residue/digit registers and sticky overflow
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_res_p   <= '0;
            r_res_m   <= '0;
            r_z       <= DIG_ZERO;
            r_z_valid <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_z       <= DIG_ZERO;
            r_z_valid <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_res_p <= '0;
                        r_res_m <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    r_res_p <= i_sum_plus << 1;
                    r_res_m <= i_sum_minus << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(DELAY - 1))
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_res_p   <= w_new_p << 1;
                    r_res_m   <= w_new_m << 1;
                    r_z       <= w_z;
                    r_z_valid <= 1'b1;
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == CW'(W - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // Adder carry-out while an operation is in flight means the residue overflowed
            if (r_state != ST_IDLE && i_sum_cout != 2'b00)
                r_ovf <= 1'b1;
        end
    end

    assign o_residue_plus  = r_res_p;
    assign o_residue_minus = r_res_m;
    assign o_z_plus        = r_z[1];
    assign o_z_minus       = r_z[0];
    assign o_z_valid       = r_z_valid;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_done          = r_done;
    assign o_ovf           = r_ovf;

endmodule

// File: tb/tb_online_residue_select.sv
// Scoreboard bench for online_residue_select: expected digits/residues are
// queued as RUN-phase sums are driven and popped whenever z_valid is seen.
module tb_online_residue_select;

    localparam int BITS  = 4;
    localparam int DELAY = 5;
    localparam int W     = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] sp = '0;
    logic [W-1:0] sm = '0;
    logic [1:0]   cout = 2'b00;
    logic [W-1:0] o_rp, o_rm;
    logic         o_zp, o_zm, o_zv, o_busy, o_done, o_ovf;

    online_residue_select #(.BITS(BITS), .DELAY(DELAY)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_start         (start),
        .i_sum_plus      (sp),
        .i_sum_minus     (sm),
        .i_sum_cout      (cout),
        .o_residue_plus  (o_rp),
        .o_residue_minus (o_rm),
        .o_z_plus        (o_zp),
        .o_z_minus       (o_zm),
        .o_z_valid       (o_zv),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_ovf           (o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   z;
        logic [W-1:0] rp;
        logic [W-1:0] rm;
        logic         done;
    } exp_t;

    exp_t         sb[$];
    int           n_run = 0;
    int           n_fail = 0;
    int           n_dig = 0;
    logic [W-1:0] run_sp[BITS];
    logic [W-1:0] run_sm[BITS];
    exp_t         run_exp[BITS];
    bit           use_model;
    bit           init_rand;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: estimate, select, rebuild top field, shift left
    function automatic exp_t model(input logic [W-1:0] p, input logic [W-1:0] m);
        int           e, z, ep, mag;
        logic [W-1:0] vp, vm;
        exp_t         r;
        e = 4 * (int'(p[W-1]) - int'(m[W-1])) + 2 * (int'(p[W-2]) - int'(m[W-2]))
            + (int'(p[W-3]) - int'(m[W-3]));
        if (e >= 1)       z = 1;
        else if (e <= -2) z = -1;
        else              z = 0;
        ep  = e - 4 * z;
        mag = (ep < 0) ? -ep : ep;
        vp  = {3'b000, p[W-4:0]};
        vm  = {3'b000, m[W-4:0]};
        if (ep > 0) vp[W-2:W-3] = mag[1:0];
        if (ep < 0) vm[W-2:W-3] = mag[1:0];
        r.rp   = vp << 1;
        r.rm   = vm << 1;
        r.z    = (z == 1) ? 2'b10 : (z == -1) ? 2'b01 : 2'b00;
        r.done = 1'b0;
        return r;
    endfunction

    // One clock; sample 1 time unit after the edge and retire any digit
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (o_zv === 1'b1) begin
            n_dig++;
            if (sb.size() == 0) begin
                chk("unexpected_digit", o_zv, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("z",    {o_zp, o_zm}, e.z);
                chk("res_p", o_rp, e.rp);
                chk("res_m", o_rm, e.rm);
                chk("done",  o_done, e.done);
            end
        end else begin
            chk("done_wo_valid", o_done, 1'b0);
        end
    endtask

    task automatic do_mult(input int glitch, input bit cout_init);
        exp_t e;
        n_dig = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start", o_busy, 1'b1);
        chk("ovf_clear",  o_ovf, 1'b0);
        for (int i = 0; i < DELAY; i++) begin
            sp    = init_rand ? W'($urandom) : '0;
            sm    = init_rand ? W'($urandom) : '0;
            cout  = (cout_init && i == 1) ? 2'b01 : 2'b00;
            start = (i == glitch);
            tick();
            chk("init_rp",   o_rp, {sp[W-2:0], 1'b0});
            chk("init_rm",   o_rm, {sm[W-2:0], 1'b0});
            chk("init_zv",   o_zv, 1'b0);
            chk("init_busy", o_busy, 1'b1);
        end
        start = 1'b0;
        cout  = 2'b00;
        for (int i = 0; i < BITS; i++) begin
            sp     = run_sp[i];
            sm     = run_sm[i];
            e      = use_model ? model(sp, sm) : run_exp[i];
            e.done = (i == BITS - 1);
            sb.push_back(e);
            tick();
        end
        chk("digit_count", n_dig, BITS);
        chk("busy_end",    o_busy, 1'b0);
        chk("sb_drained",  sb.size(), 0);
        chk("ovf_end",     o_ovf, cout_init);
        sp = '0;
        sm = '0;
        tick();
        chk("idle_zv", o_zv, 1'b0);
    endtask

    initial begin
        exp_t e;
        // Reset
        reset = 1'b1;
        tick();
        tick();
        chk("rst_outs", {o_rp, o_rm, o_zp, o_zm, o_zv, o_busy, o_done, o_ovf}, '0);
        reset = 1'b0;
        tick();

        // All-zero sums: four zero digits, zero residue
        use_model = 1'b0;
        init_rand = 1'b0;
        for (int i = 0; i < BITS; i++) begin
            run_sp[i]  = '0;
            run_sm[i]  = '0;
            run_exp[i] = '{z: 2'b00, rp: '0, rm: '0, done: 1'b0};
        end
        do_mult(-1, 1'b0);

        // Directed selections: e = 4, 3, -1, -2
        run_sp[0] = 9'b100000000; run_sm[0] = 9'b000000000;
        run_exp[0] = '{z: 2'b10, rp: 9'b000000000, rm: 9'b000000000, done: 1'b0};
        run_sp[1] = 9'b011000000; run_sm[1] = 9'b000000000;
        run_exp[1] = '{z: 2'b10, rp: 9'b000000000, rm: 9'b010000000, done: 1'b0};
        run_sp[2] = 9'b000000000; run_sm[2] = 9'b001000000;
        run_exp[2] = '{z: 2'b00, rp: 9'b000000000, rm: 9'b010000000, done: 1'b0};
        run_sp[3] = 9'b000000000; run_sm[3] = 9'b010000000;
        run_exp[3] = '{z: 2'b01, rp: 9'b100000000, rm: 9'b000000000, done: 1'b0};
        do_mult(-1, 1'b0);

        // Random sums through the reference model; start glitch in INIT
        use_model = 1'b1;
        init_rand = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < BITS; i++) begin
                run_sp[i] = W'($urandom);
                run_sm[i] = W'($urandom);
            end
            do_mult((k == 1) ? 2 : -1, 1'b0);
        end

        // Carry-out during INIT: ovf sticky through done, cleared by next start
        do_mult(-1, 1'b1);
        do_mult(-1, 1'b0);

        // Reset at the second RUN cycle: nothing further emitted
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < DELAY; i++) tick();
        sp = 9'b011000000;
        sm = '0;
        e  = model(sp, sm);
        sb.push_back(e);
        tick();
        sp    = 9'b100000000;
        reset = 1'b1;
        tick();
        chk("midrst_outs", {o_rp, o_rm, o_zp, o_zm, o_zv, o_busy, o_done, o_ovf}, '0);
        reset = 1'b0;
        n_dig = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_nodig", n_dig, 0);
        chk("midrst_busy",  o_busy, 1'b0);
        chk("midrst_sb",    sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
